// File: rtl/eth_arp_tx_if.sv
// Request/status and GMII TX signal bundle for the ARP reply transmitter.
// The master side is the ARP receive logic plus the PHY pins; the slave side is eth_arp_tx.
interface eth_arp_tx_if;
  logic [47:0] mac_s_addr;
  logic [31:0] ip_s_addr;
  logic [47:0] mac_d_addr;
  logic [31:0] ip_d_addr;
  logic        arp_reply_req;
  logic        busy;
  logic        tx_done;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;

  modport master (
    output mac_s_addr, ip_s_addr, mac_d_addr, ip_d_addr, arp_reply_req,
    input  busy, tx_done, gmii_txd, gmii_tx_en, gmii_tx_er
  );

  modport slave (
    input  mac_s_addr, ip_s_addr, mac_d_addr, ip_d_addr, arp_reply_req,
    output busy, tx_done, gmii_txd, gmii_tx_en, gmii_tx_er
  );
endinterface

// File: rtl/eth_arp_tx.sv
// GMII ARP reply transmitter: preamble/SFD, Ethernet + ARP header, zero pad,
// CRC-32 FCS and an enforced inter-frame gap. All outputs are registered.
module eth_arp_tx #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IFG_CYCLES   = 12
) (
  input  logic         aclk,
  input  logic         areset,
  eth_arp_tx_if.slave  arp
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAD, FCS, IFG} state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [7:0]  ifg_q;
  logic [31:0] crc_q;
  logic [47:0] mac_s_q, mac_d_q;
  logic [31:0] ip_s_q, ip_d_q;
  logic [7:0]  txd_q;
  logic        tx_en_q, busy_q, done_q;

  logic [41:0][7:0] hdr_b;
  logic [5:0]  hdr_idx;
  logic [7:0]  hdr_byte_d, fcs_byte_d;
  logic [31:0] crc_hdr_d, crc_pad_d, fcs_d;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int unsigned k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Each cycle the byte being loaded into txd_q is also folded into the CRC,
  // so crc_q always covers every HEADER/PAD byte already presented.
  always_comb begin
    hdr_b = {mac_d_q, mac_s_q, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
             16'h0002, mac_s_q, ip_s_q, mac_d_q, ip_d_q};
    hdr_idx = '0;
    if (state_q == HEADER && cnt_q != 6'd41)
      hdr_idx = cnt_q + 6'd1;
    hdr_byte_d = hdr_b[6'd41 - hdr_idx];
    crc_hdr_d  = crc_upd(crc_q, hdr_byte_d);
    crc_pad_d  = crc_upd(crc_q, 8'h00);
    fcs_d      = ~crc_q;
    case (cnt_q[1:0])
      2'd0:    fcs_byte_d = fcs_d[15:8];
      2'd1:    fcs_byte_d = fcs_d[23:16];
      default: fcs_byte_d = fcs_d[31:24];
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ifg_q   <= '0;
      crc_q   <= '0;
      mac_s_q <= '0;
      mac_d_q <= '0;
      ip_s_q  <= '0;
      ip_d_q  <= '0;
      txd_q   <= '0;
      tx_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (arp.arp_reply_req) begin
            mac_s_q <= arp.mac_s_addr;
            ip_s_q  <= arp.ip_s_addr;
            mac_d_q <= arp.mac_d_addr;
            ip_d_q  <= arp.ip_d_addr;
            state_q <= PREAMBLE;
            cnt_q   <= '0;
            txd_q   <= 8'h55;
            tx_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        PREAMBLE: begin
          if (cnt_q < 6'(PREAMBLE_LEN - 1)) begin
            cnt_q <= cnt_q + 6'd1;
            txd_q <= 8'h55;
          end else if (cnt_q == 6'(PREAMBLE_LEN - 1)) begin
            cnt_q <= cnt_q + 6'd1;
            txd_q <= 8'hD5;
            crc_q <= '1;
          end else begin
            state_q <= HEADER;
            cnt_q   <= '0;
            txd_q   <= hdr_byte_d;
            crc_q   <= crc_hdr_d;
          end
        end
        HEADER: begin
          if (cnt_q < 6'd41) begin
            cnt_q <= cnt_q + 6'd1;
            txd_q <= hdr_byte_d;
            crc_q <= crc_hdr_d;
          end else begin
            state_q <= PAD;
            cnt_q   <= '0;
            txd_q   <= 8'h00;
            crc_q   <= crc_pad_d;
          end
        end
        PAD: begin
          if (cnt_q < 6'd17) begin
            cnt_q <= cnt_q + 6'd1;
            txd_q <= 8'h00;
            crc_q <= crc_pad_d;
          end else begin
            state_q <= FCS;
            cnt_q   <= '0;
            txd_q   <= fcs_d[7:0];
          end
        end
        FCS: begin
          if (cnt_q < 6'd3) begin
            cnt_q <= cnt_q + 6'd1;
            txd_q <= fcs_byte_d;
          end else begin
            state_q <= IFG;
            cnt_q   <= '0;
            ifg_q   <= '0;
            txd_q   <= 8'h00;
            tx_en_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        IFG: begin
          if (ifg_q == 8'(IFG_CYCLES - 1)) begin
            state_q <= IDLE;
            ifg_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            ifg_q <= ifg_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arp.gmii_txd   = txd_q;
  assign arp.gmii_tx_en = tx_en_q;
  assign arp.gmii_tx_er = 1'b0;
  assign arp.busy       = busy_q;
  assign arp.tx_done    = done_q;

endmodule

// File: tb/tb_eth_arp_tx.sv
// Scoreboard bench for eth_arp_tx: expected frame bytes are queued at request
// time and popped by a GMII monitor; scenario tasks check timing and control.
module tb_eth_arp_tx;
  localparam int unsigned PRE = 7;
  localparam int unsigned IFG = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  eth_arp_tx_if bus();

  eth_arp_tx #(.PREAMBLE_LEN(PRE), .IFG_CYCLES(IFG)) dut (
    .aclk(clk), .areset(rst), .arp(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  int cyc = 0;
  int frames = 0, done_cnt = 0, fidx = 0;
  int rise_cyc = 0, fall_cyc = 0, last_gap = -1, busy_low_cyc = 0;
  bit in_frame = 0, have_fall = 0, prev_busy = 0;
  logic [31:0] mcrc;

  localparam logic [47:0] MAC_S = 48'h02_00_00_00_00_01;
  localparam logic [31:0] IP_S  = 32'hC0A8010A;
  localparam logic [47:0] MAC_D = 48'hAA_BB_CC_DD_EE_FF;
  localparam logic [31:0] IP_D  = 32'hC0A80164;

  function automatic logic [31:0] tb_crc(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic push_frame(input logic [47:0] ms, input logic [31:0] is,
                            input logic [47:0] md, input logic [31:0] id);
    logic [7:0]   b [60];
    logic [335:0] hv;
    logic [31:0]  c, f;
    hv = {md, ms, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002, ms, is, md, id};
    for (int i = 0; i < 42; i++) b[i] = hv[335 - 8*i -: 8];
    for (int i = 42; i < 60; i++) b[i] = 8'h00;
    for (int i = 0; i < int'(PRE); i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 60; i++) begin
      c = tb_crc(c, b[i]);
      exp_q.push_back(b[i]);
    end
    f = ~c;
    exp_q.push_back(f[7:0]);
    exp_q.push_back(f[15:8]);
    exp_q.push_back(f[23:16]);
    exp_q.push_back(f[31:24]);
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus.gmii_tx_en) begin
        ok = 1;
        break;
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      in_frame  = 0;
      have_fall = 0;
      prev_busy = 0;
    end else begin
      if (bus.gmii_tx_en) begin
        if (!in_frame) begin
          in_frame = 1;
          fidx = 0;
          rise_cyc = cyc;
          if (have_fall) last_gap = cyc - fall_cyc;
          mcrc = 32'hFFFFFFFF;
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte idx=%0d got %02h required none", fidx, bus.gmii_txd);
        end else begin
          e = exp_q.pop_front();
          if (bus.gmii_txd !== e) begin
            errors++;
            $display("FAIL frame_byte idx=%0d got %02h required %02h", fidx, bus.gmii_txd, e);
          end
        end
        checks++;
        if (bus.gmii_tx_er !== 1'b0) begin
          errors++;
          $display("FAIL tx_er idx=%0d got %b required 0", fidx, bus.gmii_tx_er);
        end
        if (fidx >= int'(PRE) + 1) mcrc = tb_crc(mcrc, bus.gmii_txd);
        fidx++;
      end else if (in_frame) begin
        in_frame = 0;
        have_fall = 1;
        fall_cyc = cyc;
        frames++;
        checks++;
        if (fidx != int'(PRE) + 65) begin
          errors++;
          $display("FAIL tx_en_length got %0d required %0d", fidx, PRE + 65);
        end
        checks++;
        if (mcrc !== 32'hDEBB20E3) begin
          errors++;
          $display("FAIL crc_residue got %08h required DEBB20E3", mcrc);
        end
      end
      if (bus.tx_done) begin
        done_cnt++;
        checks++;
        if (!(have_fall && fall_cyc == cyc)) begin
          errors++;
          $display("FAIL tx_done_timing cyc=%0d required first IFG cycle (fall=%0d)", cyc, fall_cyc);
        end
      end
      if (prev_busy && !bus.busy) busy_low_cyc = cyc;
      prev_busy = bus.busy;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.gmii_tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en got %b required 0", bus.gmii_tx_en); end
    checks++; if (bus.gmii_txd !== 8'h00) begin errors++; $display("FAIL reset_txd got %02h required 00", bus.gmii_txd); end
    checks++; if (bus.gmii_tx_er !== 1'b0) begin errors++; $display("FAIL reset_tx_er got %b required 0", bus.gmii_tx_er); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", bus.busy); end
    checks++; if (bus.tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done got %b required 0", bus.tx_done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b required 0", bus.busy); end
  endtask

  task automatic test_single();
    int f0, d0;
    bit ok;
    f0 = frames; d0 = done_cnt;
    push_frame(MAC_S, IP_S, MAC_D, IP_D);
    bus.arp_reply_req = 1'b1;
    @(negedge clk);
    bus.arp_reply_req = 1'b0;
    checks++; if (bus.gmii_tx_en !== 1'b1) begin errors++; $display("FAIL first_byte_latency tx_en got %b required 1", bus.gmii_tx_en); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_on_accept got %b required 1", bus.busy); end
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got busy required idle"); end
    repeat (2) @(negedge clk);
    checks++; if (frames - f0 != 1) begin errors++; $display("FAIL single_frames got %0d required 1", frames - f0); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_tx_done got %0d required 1", done_cnt - d0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_leftover got %0d required 0", exp_q.size()); end
    checks++; if (busy_low_cyc - fall_cyc != int'(IFG)) begin errors++; $display("FAIL ifg_busy got %0d required %0d", busy_low_cyc - fall_cyc, IFG); end
  endtask

  task automatic test_back_to_back();
    int f0;
    bit ok, started;
    f0 = frames;
    started = 0;
    push_frame(MAC_S, IP_S, MAC_D, IP_D);
    push_frame(MAC_S, IP_S, MAC_D, IP_D);
    bus.arp_reply_req = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frames == f0 + 1 && bus.gmii_tx_en) begin
        started = 1;
        break;
      end
    end
    bus.arp_reply_req = 1'b0;
    checks++; if (!started) begin errors++; $display("FAIL b2b_second_start got none required frame"); end
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got busy required idle"); end
    repeat (2) @(negedge clk);
    checks++; if (frames - f0 != 2) begin errors++; $display("FAIL b2b_frames got %0d required 2", frames - f0); end
    checks++; if (last_gap != int'(IFG) + 1) begin errors++; $display("FAIL b2b_gap got %0d required %0d", last_gap, IFG + 1); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_busy_ignore();
    int f0;
    bit ok;
    f0 = frames;
    push_frame(MAC_S, IP_S, MAC_D, IP_D);
    bus.arp_reply_req = 1'b1;
    @(negedge clk);
    bus.arp_reply_req = 1'b0;
    repeat (29) @(negedge clk);
    bus.arp_reply_req = 1'b1;
    @(negedge clk);
    bus.arp_reply_req = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ignore_busy_mid got %b required 1", bus.busy); end
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ignore_timeout got busy required idle"); end
    repeat (20) @(negedge clk);
    checks++; if (frames - f0 != 1) begin errors++; $display("FAIL ignore_frames got %0d required 1", frames - f0); end
    checks++; if (bus.gmii_tx_en !== 1'b0) begin errors++; $display("FAIL ignore_tx_en got %b required 0", bus.gmii_tx_en); end
    checks++; if (busy_low_cyc - fall_cyc != int'(IFG)) begin errors++; $display("FAIL ignore_ifg_busy got %0d required %0d", busy_low_cyc - fall_cyc, IFG); end
  endtask

  task automatic test_capture();
    int f0;
    bit ok;
    f0 = frames;
    push_frame(MAC_S, IP_S, MAC_D, IP_D);
    bus.arp_reply_req = 1'b1;
    @(negedge clk);
    bus.arp_reply_req = 1'b0;
    repeat (4) @(negedge clk);
    bus.mac_d_addr = 48'h11_22_33_44_55_66;
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL capture_timeout got busy required idle"); end
    repeat (2) @(negedge clk);
    checks++; if (frames - f0 != 1) begin errors++; $display("FAIL capture_frames got %0d required 1", frames - f0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL capture_leftover got %0d required 0", exp_q.size()); end
    bus.mac_d_addr = MAC_D;
  endtask

  task automatic test_reset_mid();
    int f0, d0;
    bit ok, hit;
    f0 = frames; d0 = done_cnt;
    hit = 0;
    push_frame(MAC_S, IP_S, MAC_D, IP_D);
    bus.arp_reply_req = 1'b1;
    @(negedge clk);
    bus.arp_reply_req = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_frame && fidx >= 55) begin
        hit = 1;
        break;
      end
    end
    checks++; if (!hit) begin errors++; $display("FAIL abort_reach_pad got none required pad"); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.gmii_tx_en !== 1'b0) begin errors++; $display("FAIL abort_tx_en got %b required 0", bus.gmii_tx_en); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b required 0", bus.busy); end
    checks++; if (bus.gmii_txd !== 8'h00) begin errors++; $display("FAIL abort_txd got %02h required 00", bus.gmii_txd); end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_tx_done got %0d required %0d", done_cnt, d0); end
    checks++; if (frames != f0) begin errors++; $display("FAIL abort_frames got %0d required %0d", frames, f0); end
    checks++; if (bus.gmii_tx_en !== 1'b0) begin errors++; $display("FAIL abort_quiet got %b required 0", bus.gmii_tx_en); end
    push_frame(MAC_S, IP_S, MAC_D, IP_D);
    bus.arp_reply_req = 1'b1;
    @(negedge clk);
    bus.arp_reply_req = 1'b0;
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL recover_timeout got busy required idle"); end
    repeat (2) @(negedge clk);
    checks++; if (frames - f0 != 1) begin errors++; $display("FAIL recover_frames got %0d required 1", frames - f0); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL recover_tx_done got %0d required 1", done_cnt - d0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL recover_leftover got %0d required 0", exp_q.size()); end
  endtask

  initial begin
    bus.mac_s_addr    = MAC_S;
    bus.ip_s_addr     = IP_S;
    bus.mac_d_addr    = MAC_D;
    bus.ip_d_addr     = IP_D;
    bus.arp_reply_req = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_capture();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog got timeout required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/eth_arp_tx.md
Name: eth_arp_tx

Overview:
- GMII transmit-side counterpart to the receive path: builds and sends a complete ARP reply frame on request.
- Frame contents: preamble/SFD, Ethernet header, ARP reply payload, zero padding to minimum length, CRC-32 FCS, then an enforced inter-frame gap.
- Driven by the ARP receive logic, which supplies the requester's MAC/IP and a request strobe.
- Drives the GMII TX pins directly, in the GMII TX clock domain.

Parameters:
- PREAMBLE_LEN, 7: number of 0x55 preamble bytes before the SFD (0xD5).
- IFG_CYCLES, 12: idle cycles enforced after the last FCS byte before the next frame may start (legal range 1..255).

Ports:
- aclk  input  1  GMII TX clock, 125 MHz; all logic on the rising edge.
- areset  input  1  asynchronous, active-high reset.
- mac_s_addr  input  48  local MAC; frame source and ARP SHA.
- ip_s_addr  input  32  local IP; ARP SPA.
- mac_d_addr  input  48  requester MAC; frame destination and ARP THA.
- ip_d_addr  input  32  requester IP; ARP TPA.
- arp_reply_req  input  1  request to send one reply; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-cycle pulse on completion of the last FCS byte.
- gmii_txd  output  8  transmit data.
- gmii_tx_en  output  1  transmit enable.
- gmii_tx_er  output  1  transmit error; tied 0.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; all counters 0; gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, busy=0, tx_done=0.
- All outputs are registered.
- Request acceptance:
  - In IDLE, arp_reply_req=1 at edge N captures all four address inputs into internal registers.
  - The first preamble byte appears on gmii_txd with gmii_tx_en=1 in cycle N+1.
  - Input changes after capture do not affect the frame in progress.
- States and transitions:
  - IDLE: waits for an accepted request.
  - PREAMBLE: PREAMBLE_LEN bytes of 0x55, then one byte 0xD5.
  - HEADER: 42 bytes, in this order:
    - destination MAC = mac_d.
    - source MAC = mac_s.
    - ethertype 0x0806.
    - HTYPE 0x0001, PTYPE 0x0800, HLEN 0x06, PLEN 0x04, OPER 0x0002.
    - SHA = mac_s, SPA = ip_s, THA = mac_d, TPA = ip_d.
  - PAD: 18 bytes of 0x00, giving 60 bytes before the FCS.
  - FCS: 4 bytes.
  - IFG: gmii_tx_en=0 and gmii_txd=0x00 for IFG_CYCLES cycles, then return to IDLE.
- Field byte order: multi-byte fields are sent most-significant byte first (addr[47:40] first).
- Byte counting: a single 6-bit byte counter indexes HEADER and PAD; it resets on each state entry.
- CRC:
  - Reflected CRC-32, polynomial 0xEDB88320, initialised to 0xFFFFFFFF at SFD.
  - Updated bytewise over all 60 HEADER+PAD bytes.
  - FCS = bitwise NOT of the register, sent least-significant byte first.
- gmii_tx_en is high for exactly PREAMBLE_LEN+1+64 = 72 contiguous cycles (default).
- tx_done is high in the first IFG cycle only.
- Request while busy: ignored, not queued.
  - A request held high across completion is re-sampled in IDLE.
  - Back-to-back frames are therefore separated by exactly IFG_CYCLES idle cycles, plus the one IDLE acceptance cycle.
- Reset mid-frame: gmii_tx_en drops in the same cycle (asynchronous); no FCS, no IFG, no tx_done.
- Request and reset deasserting together: the request is ignored until the first edge after areset is low.

Test Plan:
- Single reply, mac_s=02:00:00:00:00:01, ip_s=C0A8010A, mac_d=AA:BB:CC:DD:EE:FF, ip_d=C0A80164, one-cycle req pulse -> tx_en rises next cycle for 72 cycles; byte 8 = 0xAA, byte 20..21 = 0x08,0x06, byte 28..29 = 0x00,0x02, bytes 50..67 = 0x00; reflected CRC register (no final invert) over bytes 8..71 = 0xDEBB20E3; tx_done pulses once.
- req held high for two frames -> second frame's first 0x55 appears exactly IFG_CYCLES+1 = 13 cycles after tx_en falls; both frames byte-identical.
- req pulsed in cycle 30 of an active frame -> ignored; no second frame; busy stays high until IFG ends.
- mac_d_addr changed to 11:22:33:44:55:66 in cycle 5 of a frame -> current frame still carries AA:BB:CC:DD:EE:FF in both the destination and THA fields.
- areset asserted in the middle of PAD -> gmii_tx_en=0, busy=0, gmii_txd=0x00 within the same cycle; no tx_done; the next request after release produces a complete valid frame.
